// File: rtl/operand_bypass_pkg.sv
// operand_bypass_pkg: shared select encodings, latency classes and tracker entry type
package operand_bypass_pkg;
  localparam int SEL_RF     = 0;
  localparam int SEL_WB     = 1;
  localparam int SEL_STAGE0 = 2;
  localparam int LAT_ALU    = 0;
  localparam int LAT_LOAD   = 1;
  localparam int LAT_MUL    = 2;
  localparam int MAX_AW     = 8;
  localparam int MAX_LW     = 4;
  typedef struct packed {
    logic              v;
    logic [MAX_AW-1:0] addr;
    logic [MAX_LW-1:0] lat;
  } trk_entry_t;
endpackage

// File: rtl/operand_bypass_tracker.sv
// bypass_tracker: in-flight write shift register, one entry per result stage
module bypass_tracker
  import operand_bypass_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_adv,
  input  logic                    i_flush,
  input  trk_entry_t              i_new,
  output trk_entry_t [STAGES-1:0] o_ent
);
  trk_entry_t [STAGES-1:0] r_ent;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_ent <= '0;
    else if (i_flush) r_ent <= '0;
    else if (i_adv) begin
      r_ent[0] <= i_new;
      for (int k = 1; k < STAGES; k++) r_ent[k] <= r_ent[k-1];
    end
  end
  assign o_ent = r_ent;
endmodule

// File: rtl/operand_bypass.sv
// operand_bypass: youngest-first operand forwarding, hazard stall and registered EX operands
module operand_bypass
  import operand_bypass_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NRP    = 2,
  parameter int STAGES = 3,
  parameter int SEL_W  = $clog2(STAGES+2)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     id_valid,
  input  logic [NRP*REG_AW-1:0]    id_raddr,
  input  logic [NRP*DATA_W-1:0]    id_rf_data,
  input  logic                     id_wen,
  input  logic [REG_AW-1:0]        id_waddr,
  input  logic [SEL_W-1:0]         id_wlat,
  input  logic [STAGES*DATA_W-1:0] stage_data,
  input  logic                     wb_wen,
  input  logic [REG_AW-1:0]        wb_waddr,
  input  logic [DATA_W-1:0]        wb_wdata,
  input  logic                     ex_hold,
  input  logic                     flush,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [NRP*DATA_W-1:0]    ex_opnd,
  output logic [NRP*SEL_W-1:0]     ex_fwd_sel
);
  trk_entry_t [STAGES-1:0] w_ent;
  trk_entry_t              w_new;
  logic [NRP-1:0]          w_haz;
  logic [NRP*DATA_W-1:0]   w_opnd;
  logic [NRP*SEL_W-1:0]    w_sel;
  logic                    w_adv, w_go;
  logic                    r_ex_valid;
  logic [NRP*DATA_W-1:0]   r_ex_opnd;
  logic [NRP*SEL_W-1:0]    r_ex_sel;
  assign stall = ex_hold | (id_valid & |w_haz);
  assign w_adv = ~ex_hold & ~flush;
  assign w_go  = id_valid & ~stall;
  assign w_new = '{v: w_go & id_wen & (id_waddr != '0), addr: MAX_AW'(id_waddr), lat: MAX_LW'(id_wlat)};
  bypass_tracker #(.STAGES(STAGES)) u_trk (
    .clk(clk), .resetn(resetn), .i_adv(w_adv), .i_flush(flush), .i_new(w_new), .o_ent(w_ent)
  );
  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [REG_AW-1:0] w_a;
    logic [DATA_W-1:0] w_d;
    logic [SEL_W-1:0]  w_s;
    logic              w_h;
    assign w_a = id_raddr[p*REG_AW +: REG_AW];
    // oldest-to-youngest scan so the youngest match overwrites, ready or not
    always_comb begin
      w_d = id_rf_data[p*DATA_W +: DATA_W];
      w_s = SEL_W'(SEL_RF);
      w_h = 1'b0;
      if (w_a == '0) w_d = '0;
      else begin
        if (wb_wen && wb_waddr == w_a) begin
          w_d = wb_wdata;
          w_s = SEL_W'(SEL_WB);
        end
        for (int k = STAGES-1; k >= 0; k--)
          if (w_ent[k].v && w_ent[k].addr == MAX_AW'(w_a)) begin
            w_d = stage_data[k*DATA_W +: DATA_W];
            w_s = SEL_W'(SEL_STAGE0 + k);
            w_h = MAX_LW'(k) < w_ent[k].lat;
          end
      end
    end
    assign w_haz[p]                  = w_h;
    assign w_opnd[p*DATA_W +: DATA_W] = w_d;
    assign w_sel[p*SEL_W +: SEL_W]    = w_s;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ex_valid <= 1'b0;
      r_ex_opnd  <= '0;
      r_ex_sel   <= '0;
    end else if (flush) r_ex_valid <= 1'b0;
    else if (w_adv) begin
      r_ex_valid <= w_go;
      if (w_go) begin
        r_ex_opnd <= w_opnd;
        r_ex_sel  <= w_sel;
      end
    end
  end
  assign ex_valid   = r_ex_valid;
  assign ex_opnd    = r_ex_opnd;
  assign ex_fwd_sel = r_ex_sel;
endmodule

// File: tb/tb_operand_bypass.sv
// tb_operand_bypass: directed vectors for forwarding priority, stalls, flush, hold and reset
module tb_operand_bypass;
  import operand_bypass_pkg::*;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        id_valid = 1'b0;
  logic [9:0]  id_raddr = '0;
  logic [63:0] id_rf_data = '0;
  logic        id_wen = 1'b0;
  logic [4:0]  id_waddr = '0;
  logic [2:0]  id_wlat = '0;
  logic [95:0] stage_data = '0;
  logic        wb_wen = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        ex_hold = 1'b0;
  logic        flush = 1'b0;
  logic        stall, ex_valid;
  logic [63:0] ex_opnd;
  logic [5:0]  ex_fwd_sel;
  int          n_tests = 0;
  int          n_fail = 0;
  operand_bypass dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_raddr(id_raddr), .id_rf_data(id_rf_data),
    .id_wen(id_wen), .id_waddr(id_waddr), .id_wlat(id_wlat), .stage_data(stage_data),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .ex_hold(ex_hold), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_opnd(ex_opnd), .ex_fwd_sel(ex_fwd_sel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic id(input logic v, input logic [4:0] a0, input logic [4:0] a1, input logic [31:0] d0,
                    input logic [31:0] d1, input logic w, input logic [4:0] wa, input int lat);
    id_valid   = v;
    id_raddr   = {a1, a0};
    id_rf_data = {d1, d0};
    id_wen     = w;
    id_waddr   = wa;
    id_wlat    = 3'(lat);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    #1 resetn = 1'b0;
    #1;
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_opnd", ex_opnd, 64'd0);
    chk("rst_sel", 64'(ex_fwd_sel), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    // ALU -> dependent ALU: no stall, forward from stage 0
    id(1, 1, 2, 0, 0, 1, 3, LAT_ALU);
    step();
    id(1, 3, 1, 32'hAAAA, 32'h55, 1, 4, LAT_ALU);
    stage_data[31:0] = 32'h1234;
    #1 chk("alu_stall", 64'(stall), 64'd0);
    step();
    chk("alu_valid", 64'(ex_valid), 64'd1);
    chk("alu_opnd", ex_opnd, {32'h55, 32'h1234});
    chk("alu_sel", 64'(ex_fwd_sel), 64'd2);
    // load-use: exactly one stall cycle, then both ports from MEM1
    id(1, 1, 1, 0, 0, 1, 3, LAT_LOAD);
    step();
    id(1, 3, 3, 32'hBAD, 32'hBAD, 1, 4, LAT_ALU);
    #1 chk("ld_stall1", 64'(stall), 64'd1);
    step();
    chk("ld_bubble", 64'(ex_valid), 64'd0);
    chk("ld_stall2", 64'(stall), 64'd0);
    stage_data[63:32] = 32'hCAFEF00D;
    step();
    chk("ld_valid", 64'(ex_valid), 64'd1);
    chk("ld_opnd", ex_opnd, {32'hCAFEF00D, 32'hCAFEF00D});
    chk("ld_sel", 64'(ex_fwd_sel), 64'o33);
    // mul latency 2: two stall cycles, then forward from MEM2
    id(1, 0, 0, 0, 0, 1, 6, LAT_MUL);
    step();
    id(1, 6, 0, 0, 0, 0, 0, LAT_ALU);
    #1 chk("mul_stall1", 64'(stall), 64'd1);
    step();
    chk("mul_stall2", 64'(stall), 64'd1);
    step();
    chk("mul_stall3", 64'(stall), 64'd0);
    stage_data[95:64] = 32'hABC;
    step();
    chk("mul_opnd", ex_opnd, {32'h0, 32'hABC});
    chk("mul_sel", 64'(ex_fwd_sel), 64'd4);
    // two writers of r7: younger not-ready one wins, older ready value never captured
    id(1, 0, 0, 0, 0, 1, 7, LAT_ALU);
    step();
    id(1, 1, 0, 32'h1111, 0, 1, 7, LAT_LOAD);
    step();
    id(1, 7, 0, 32'h7777, 0, 0, 0, LAT_ALU);
    stage_data[31:0]  = 32'h22;
    stage_data[63:32] = 32'h11;
    #1 chk("r7_stall", 64'(stall), 64'd1);
    step();
    chk("r7_bubble", 64'(ex_valid), 64'd0);
    chk("r7_nocap", ex_opnd, {32'h0, 32'h1111});
    chk("r7_stall2", 64'(stall), 64'd0);
    stage_data[63:32] = 32'h77;
    step();
    chk("r7_opnd", ex_opnd, {32'h0, 32'h77});
    chk("r7_sel", 64'(ex_fwd_sel), 64'd3);
    // WB same-cycle forward beats RF; r0 read with an r0 writer ahead is 0, no stall
    id(1, 0, 0, 0, 0, 1, 0, LAT_LOAD);
    step();
    wb_wen = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'hDEAD;
    id(1, 9, 0, 32'hBEEF, 32'h999, 0, 0, LAT_ALU);
    #1 chk("wb_stall", 64'(stall), 64'd0);
    step();
    wb_wen = 1'b0;
    chk("wb_opnd", ex_opnd, {32'h0, 32'hDEAD});
    chk("wb_sel", 64'(ex_fwd_sel), 64'd1);
    // flush with hold during load-use stall
    id(1, 0, 0, 0, 0, 1, 5, LAT_LOAD);
    step();
    chk("fl_pre_valid", 64'(ex_valid), 64'd1);
    id(1, 5, 0, 32'h5, 0, 0, 0, LAT_ALU);
    #1 chk("fl_stall0", 64'(stall), 64'd1);
    ex_hold = 1'b1; flush = 1'b1;
    #1 chk("fl_stall1", 64'(stall), 64'd1);
    step();
    flush = 1'b0;
    chk("fl_valid", 64'(ex_valid), 64'd0);
    #1 chk("fl_hold_stall", 64'(stall), 64'd1);
    ex_hold = 1'b0;
    #1 chk("fl_stall2", 64'(stall), 64'd0);
    step();
    chk("fl_post_valid", 64'(ex_valid), 64'd1);
    chk("fl_post_opnd", ex_opnd, {32'h0, 32'h5});
    chk("fl_post_sel", 64'(ex_fwd_sel), 64'd0);
    // reset mid-run with a valid r5 writer in flight
    id(1, 1, 0, 32'h1, 0, 1, 5, LAT_ALU);
    step();
    resetn = 1'b0;
    #1;
    chk("mrst_valid", 64'(ex_valid), 64'd0);
    chk("mrst_opnd", ex_opnd, 64'd0);
    chk("mrst_sel", 64'(ex_fwd_sel), 64'd0);
    resetn = 1'b1;
    id(1, 5, 0, 32'h5555, 0, 0, 0, LAT_ALU);
    #1 chk("mrst_stall", 64'(stall), 64'd0);
    step();
    chk("mrst_r5_sel", 64'(ex_fwd_sel), 64'd0);
    chk("mrst_r5_opnd", ex_opnd, {32'h0, 32'h5555});
    // hold freezes the EX slot
    id(1, 1, 0, 32'h42, 0, 0, 0, LAT_ALU);
    ex_hold = 1'b1;
    #1 chk("hold_stall", 64'(stall), 64'd1);
    step();
    chk("hold_opnd", ex_opnd, {32'h0, 32'h5555});
    ex_hold = 1'b0;
    step();
    chk("unhold_opnd", ex_opnd, {32'h0, 32'h42});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_bypass.md
# operand_bypass

Parametrised operand bypass and hazard unit for the integer pipeline. It sits at the ID→EX boundary and replaces the fixed per-operand forwarding selects with the following pieces:
- an in-flight write tracker;
- youngest-first forwarding across `STAGES` result stages plus writeback;
- load-use / multi-cycle-latency stall generation;
- registered EX operands.

It is generalised over data width, register-address width, read-port count and pipeline depth.

## Interface
- `DATA_W`, 32, operand/result width
- `REG_AW`, 5, register address width; register 0 is hard zero
- `NRP`, 2, read ports per instruction
- `STAGES`, 3, tracked result stages (0=EX, 1=MEM1, 2=MEM2), writeback is separate
- `SEL_W`, `$clog2(STAGES+2)`, forward-select width
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  ID holds a valid instruction
- `id_raddr`  in  NRP*REG_AW  source register addresses, port p at `[p*REG_AW +: REG_AW]`
- `id_rf_data`  in  NRP*DATA_W  raw register-file read data
- `id_wen`  in  1  instruction writes a GPR
- `id_waddr`  in  REG_AW  destination register
- `id_wlat`  in  SEL_W  first stage index whose `stage_data` holds the result (0 ALU, 1 load, 2 mul)
- `stage_data`  in  STAGES*DATA_W  current result of each stage
- `wb_wen`  in  1  writeback valid this cycle
- `wb_waddr`  in  REG_AW  writeback address
- `wb_wdata`  in  DATA_W  writeback data
- `ex_hold`  in  1  EX and later stages frozen
- `flush`  in  1  kill all in-flight tracked writes and the EX slot
- `stall`  out  1  ID must not advance (combinational)
- `ex_valid`  out  1  EX operand slot valid (registered)
- `ex_opnd`  out  NRP*DATA_W  registered operands
- `ex_fwd_sel`  out  NRP*SEL_W  registered source code per port: 0 RF, 1 WB, 2+k stage k

## Operation
- Tracker: `STAGES` entries `{v, addr, lat}`; entry k describes the instruction now in stage k.
- Advance occurs when `ex_hold`=0 and `flush`=0.
- On advance:
  - entry[k+1]←entry[k];
  - entry[STAGES-1] retires; it is the `wb_*` port owner next cycle;
  - entry[0]←`{id_valid & ~stall & id_wen & (id_waddr!=0), id_waddr, id_wlat}`;
  - the stalled case loads an invalid entry (bubble).
- Per port p, with address a and a≠0, the match search is youngest first: entry[0], …, entry[STAGES-1], then WB (`wb_wen & wb_waddr==a`), then RF.
  - The first hit decides the source.
  - A stage-k hit is ready iff k ≥ entry.lat. If ready, the data is `stage_data[k]`; if not ready, the port is a hazard.
- a=0 → operand 0, select 0, never a hazard.
- `stall` = `ex_hold | (id_valid & any port hazard)`.
- EX slot on advance:
  - `ex_valid`←`id_valid & ~stall`;
  - `ex_opnd`/`ex_fwd_sel`←the selected values when valid, otherwise unchanged.
- On `ex_hold`: tracker and EX slot hold.
- `flush` priority: flush > hold > advance. Flush clears every tracker v and `ex_valid` at the next edge.

## Timing
- Reset (async, `resetn`=0): all tracker v=0, `ex_valid`=0, `ex_opnd`=0, `ex_fwd_sel`=0. Hence `stall`=0 unless `ex_hold`.
- Operand selection is same-cycle combinational from ID inputs; the EX slot has 1-cycle latency.
- A dependent ALU op directly after an ALU producer gets zero stall cycles (entry[0], lat 0).
- A dependent op directly after a load (lat 1) gets exactly 1 stall cycle, then forwards from MEM1. With lat 2 it gets 2 stall cycles.
- Same-cycle WB write and ID read of the same register → forwarded from WB, not RF.
- Multiple matches: the youngest wins, even when it is not ready. The stall is taken; an older ready value is never used.
- A `flush` asserted while stalled clears the hazard source; `stall` drops the following cycle.
- Deassertion of `resetn` is synchronised outside this block.

## Structure
- Package `operand_bypass_pkg`:
  - select encoding localparams `SEL_RF`=0, `SEL_WB`=1, `SEL_STAGE0`=2;
  - latency class constants `LAT_ALU`=0, `LAT_LOAD`=1, `LAT_MUL`=2;
  - tracker entry struct.
- Sub-module `bypass_tracker`: holds the entry shift register with advance, bubble and flush behaviour, and exposes the entry vectors.
- Per-port match/priority logic is a generate loop over `NRP` in the top level.

## Test plan
- Reset mid-run with entries valid → all outputs 0 immediately; the first post-reset read of r5 selects RF (`ex_fwd_sel`=0).
- `addu r3,…` then `subu r4,r3,…`, with `stage_data[0]`=0x1234 → no stall; `ex_opnd` port0=0x1234, `ex_fwd_sel`=2.
- `lw r3` then `addu r4,r3,r3` → `stall`=1 for exactly 1 cycle. Next cycle both ports = `stage_data[1]` value 0xCAFEF00D, select 3.
- Two writers of r7 in stage 0 (lat 1, not ready) and stage 1 (ready, 0x11) → stall; the 0x11 value is never captured. Next cycle r7 resolves from stage 1 with the younger value.
- WB writes r9=0xDEAD in the same cycle ID reads r9 with RF=0xBEEF → `ex_opnd`=0xDEAD, select 1. A read of r0 with a pending r0 write → 0, no stall.
- `flush` during a load-use stall together with `ex_hold`=1 → next edge `ex_valid`=0, all entries invalid, `stall` falls to `ex_hold` only.
